// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer and its display path.
// Phase 7 (PH_FLASH) is reachable only when NIGHT_FLASH_EN is defined.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_ALL_RED  = 3'd0,
    PH_A_GREEN  = 3'd1,
    PH_A_YELLOW = 3'd2,
    PH_CLR_A    = 3'd3,
    PH_B_GREEN  = 3'd4,
    PH_B_YELLOW = 3'd5,
    PH_CLR_B    = 3'd6,
    PH_FLASH    = 3'd7
  } phase_e;

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int ALLRED_TICKS = 2;
  localparam int CLR_TICKS    = 1;

  // Normal successor; CLR_B wraps to A_GREEN, anything unexpected falls back to ALL_RED.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      PH_ALL_RED:  n = PH_A_GREEN;
      PH_A_GREEN:  n = PH_A_YELLOW;
      PH_A_YELLOW: n = PH_CLR_A;
      PH_CLR_A:    n = PH_B_GREEN;
      PH_B_GREEN:  n = PH_B_YELLOW;
      PH_B_YELLOW: n = PH_CLR_B;
      PH_CLR_B:    n = PH_A_GREEN;
      default:     n = PH_ALL_RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Combinational phase -> lamp decode for both roads; also used by the display block.
// Only phases 1 and 4 drive a green, so both roads can never be green together.
module lamp_decode
  import traffic_pkg::*;
(
  input  logic [2:0] i_phase,
  input  logic       i_flash_lit,
  output logic [2:0] o_lamp_a,
  output logic [2:0] o_lamp_b
);

  always_comb begin
    o_lamp_a = LAMP_R;
    o_lamp_b = LAMP_R;
    case (i_phase)
      PH_A_GREEN:  o_lamp_a = LAMP_G;
      PH_A_YELLOW: o_lamp_a = LAMP_Y;
      PH_B_GREEN:  o_lamp_b = LAMP_G;
      PH_B_YELLOW: o_lamp_b = LAMP_Y;
      PH_FLASH: begin
        o_lamp_a = i_flash_lit ? LAMP_Y : LAMP_OFF;
        o_lamp_b = i_flash_lit ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer: tick-driven countdown, early-green skip, hold freeze.
// Define NIGHT_FLASH_EN to add the night input and the yellow-flash phase (sel=7).
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int DUR_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [DUR_W-1:0] g_end,
  input  logic [DUR_W-1:0] y_end,
  input  logic             hold,
  input  logic             skip,
`ifdef NIGHT_FLASH_EN
  input  logic             night,
`endif
  output logic [2:0]       sel,
  output logic [2:0]       lamp_a,
  output logic [2:0]       lamp_b,
  output logic [DUR_W-1:0] phase_left,
  output logic             phase_done
);

  phase_e           r_sel;
  logic [DUR_W-1:0] r_left;
  logic             r_done;
  phase_e           w_nsel;
  phase_e           w_succ;
  logic [DUR_W-1:0] w_nleft;
  logic             w_done;
  logic             w_tk;
  logic             w_green;
  logic             w_adv;
  logic             w_lit;

  // Duration loaded on entry to phase p; a programmed 0 counts as 1 tick.
  function automatic logic [DUR_W-1:0] dur_of(input phase_e p,
                                               input logic [DUR_W-1:0] g,
                                               input logic [DUR_W-1:0] y);
    logic [DUR_W-1:0] d;
    case (p)
      PH_ALL_RED:              d = DUR_W'(ALLRED_TICKS);
      PH_A_GREEN, PH_B_GREEN:  d = (g == '0) ? DUR_W'(1) : g;
      PH_A_YELLOW, PH_B_YELLOW: d = (y == '0) ? DUR_W'(1) : y;
      PH_FLASH:                d = '0;
      default:                 d = DUR_W'(CLR_TICKS);
    endcase
    return d;
  endfunction

`ifdef NIGHT_FLASH_EN
  logic r_lit;
  logic w_nlit;
`endif

  always_comb begin
    w_nsel  = r_sel;
    w_nleft = r_left;
    w_done  = 1'b0;
    w_adv   = 1'b0;
    w_tk    = tick & ~hold;
    w_green = (r_sel == PH_A_GREEN) || (r_sel == PH_B_GREEN);
    w_succ  = next_phase(r_sel);
`ifdef NIGHT_FLASH_EN
    w_nlit  = r_lit;
    if (night) begin
      w_succ = PH_FLASH;
    end
`endif
    if (r_sel == PH_FLASH) begin
`ifdef NIGHT_FLASH_EN
      if (w_tk) begin
        if (!night) begin
          w_nsel  = PH_ALL_RED;
          w_nleft = DUR_W'(ALLRED_TICKS);
          w_done  = 1'b1;
          w_nlit  = 1'b0;
        end else begin
          w_nlit = ~r_lit;
        end
      end
`else
      w_nsel  = PH_ALL_RED;
      w_nleft = DUR_W'(ALLRED_TICKS);
      w_done  = 1'b1;
`endif
    end else begin
      if (skip && w_green) begin
        w_adv = 1'b1;
      end else if (w_tk) begin
        if (r_left > DUR_W'(1)) begin
          w_nleft = r_left - DUR_W'(1);
        end else begin
          w_adv = 1'b1;
        end
      end
`ifdef NIGHT_FLASH_EN
      // Night request cuts a green short straight into flash.
      if (night && w_green) begin
        w_adv = 1'b1;
      end
`endif
      if (w_adv) begin
        w_nsel  = w_succ;
        w_nleft = dur_of(w_succ, g_end, y_end);
        w_done  = 1'b1;
`ifdef NIGHT_FLASH_EN
        w_nlit  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= PH_ALL_RED;
      r_left <= DUR_W'(ALLRED_TICKS);
      r_done <= 1'b0;
    end else begin
      r_sel  <= w_nsel;
      r_left <= w_nleft;
      r_done <= w_done;
    end
  end

`ifdef NIGHT_FLASH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lit <= 1'b0;
    end else begin
      r_lit <= w_nlit;
    end
  end
  assign w_lit = r_lit;
`else
  assign w_lit = 1'b0;
`endif

  lamp_decode u_lamp_decode (
    .i_phase     (r_sel),
    .i_flash_lit (w_lit),
    .o_lamp_a    (lamp_a),
    .o_lamp_b    (lamp_b)
  );

  assign sel        = r_sel;
  assign phase_left = r_left;
  assign phase_done = r_done;

endmodule
